// File: rtl/cpu_pkg.sv
// Shared fetch-side types: FSM states, default widths
// and the {pc, inst} entry carried through the fetch buffer.
package cpu_pkg;

  localparam int CPU_AW = 32;
  localparam int CPU_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [CPU_AW-1:0] pc;
    logic [CPU_DW-1:0] inst;
  } fetch_t;

endpackage

// File: rtl/ifetch_buf_if.sv
// Fetch buffer bus: PC address handshake, memory
// req/ack side and decode valid/ready side.
interface ifetch_buf_if
  import cpu_pkg::*;
#(
  parameter int AW = CPU_AW,
  parameter int DW = CPU_DW
);

  logic [AW-1:0] addr_in;
  logic          addr_valid;
  logic          addr_ready;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;

  modport slave (
    input  addr_in, addr_valid, flush,
    input  mem_ack, mem_rdata, inst_ready,
    output addr_ready, mem_req, mem_addr,
    output inst_valid, inst_out, inst_pc
  );

  modport master (
    output addr_in, addr_valid, flush,
    output mem_ack, mem_rdata, inst_ready,
    input  addr_ready, mem_req, mem_addr,
    input  inst_valid, inst_out, inst_pc
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/clear; head reads as
// zero while empty so it never shows stale entries.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !i_clear && w_push)
      r_mem[r_wptr] <= i_din;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: one outstanding memory request,
// credit-based PC back-pressure and flush with drain.
module ifetch_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = CPU_AW,
  parameter int DW    = CPU_DW
) (
  input  logic         clk,
  input  logic         rst_n,
  ifetch_buf_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  fetch_state_e     r_state;
  fetch_state_e     w_next;
  logic [AW-1:0]    r_addr;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_occ;
  logic [AW+DW-1:0] w_head;
  logic             w_empty;
  logic             w_ready;
  logic             w_req;
  logic             w_accept;
  logic             w_push;

  // an in-flight live request already owns a FIFO slot
  assign w_occ = w_count + CW'(r_state == REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)    w_next = REQ;
      REQ: begin
        if (bus.mem_ack)        w_next = IDLE;
        else if (bus.flush)     w_next = DRAIN;
      end
      DRAIN:   if (bus.mem_ack) w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  always_comb begin
    w_req    = (r_state != IDLE);
    w_ready  = rst_n && (r_state == IDLE)
            && (w_occ < CAP) && !bus.flush;
    w_accept = w_ready && bus.addr_valid;
    w_push   = (r_state == REQ) && bus.mem_ack
            && !bus.flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        r_addr <= '0;
    else if (w_accept) r_addr <= bus.addr_in;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (bus.inst_ready),
    .i_clear (bus.flush),
    .i_din   ({r_addr, bus.mem_rdata}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign bus.addr_ready = w_ready;
  assign bus.mem_req    = w_req;
  assign bus.mem_addr   = r_addr;
  assign bus.inst_valid = !w_empty;
  assign bus.inst_pc    = w_head[AW+DW-1:DW];
  assign bus.inst_out   = w_head[DW-1:0];

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: directed scenarios
// plus randomized traffic against a queue-based model.
module tb_ifetch_buf;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ifetch_buf_if #(.AW(32), .DW(32)) bus ();

  ifetch_buf #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d);
    int n = 0;
    bus.addr_in    = a;
    bus.addr_valid = 1'b1;
    #1;
    while (!bus.addr_ready && n < 20) begin
      tick();
      #1;
      n++;
    end
    total++;
    if (bus.addr_ready !== 1'b1) begin
      bad++;
      $display("FAIL fetch_accept addr=%h ready=%b need=1",
               a, bus.addr_ready);
    end
    tick();
    bus.addr_valid = 1'b0;
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = d;
    tick();
    bus.mem_ack    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.addr_valid = 1'b1;
    bus.addr_in    = 32'h55;
    tick();
    tick();
    #1;
    total++;
    if (bus.addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%b need=0", bus.addr_ready);
    end
    total++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_mem req=%b addr=%h need 0/0",
               bus.mem_req, bus.mem_addr);
    end
    total++;
    if (bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0
        || bus.inst_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_inst v=%b out=%h pc=%h need 0/0/0",
               bus.inst_valid, bus.inst_out, bus.inst_pc);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.addr_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release_ready got=%b need=1",
               bus.addr_ready);
    end
    bus.addr_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.addr_in    = 32'h100;
    bus.addr_valid = 1'b1;
    tick();
    bus.addr_valid = 1'b0;
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL single_req req=%b addr=%h need 1/100",
               bus.mem_req, bus.mem_addr);
    end
    tick();
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_hold req=%b rdy=%b need 1/0",
               bus.mem_req, bus.addr_ready);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hE3A01005;
    tick();
    bus.mem_ack   = 1'b0;
    #1;
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100
        || bus.inst_out !== 32'hE3A01005) begin
      bad++;
      $display("FAIL single_out v=%b pc=%h out=%h need 1/100/e3a01005",
               bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    #1;
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop v=%b need=0", bus.inst_valid);
    end
  endtask

  task automatic test_fill();
    logic [31:0] e;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      fetch(32'(i * 4), 32'(i * 4) ^ 32'hA5A50000);
    bus.addr_in    = 32'h10;
    bus.addr_valid = 1'b1;
    #1;
    total++;
    if (bus.addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_bp ready=%b need=0", bus.addr_ready);
    end
    tick();
    #1;
    total++;
    if (bus.addr_ready !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fill_bp2 rdy=%b req=%b need 0/0",
               bus.addr_ready, bus.mem_req);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    #1;
    total++;
    if (bus.addr_ready !== 1'b1) begin
      bad++;
      $display("FAIL fill_credit ready=%b need=1", bus.addr_ready);
    end
    tick();
    bus.addr_valid = 1'b0;
    #1;
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL fill_req req=%b addr=%h need 1/10",
               bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h10 ^ 32'hA5A50000;
    tick();
    bus.mem_ack   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      e = 32'(i * 4);
      #1;
      total++;
      if (bus.inst_pc !== e || bus.inst_out !== (e ^ 32'hA5A50000)) begin
        bad++;
        $display("FAIL fill_order pc=%h out=%h need pc=%h",
                 bus.inst_pc, bus.inst_out, e);
      end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
    end
    #1;
    total++;
    if (bus.inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL fill_empty v=%b need=0", bus.inst_valid);
    end
  endtask

  task automatic test_flush_pending();
    bus.inst_ready = 1'b0;
    fetch(32'h30, 32'h1111);
    bus.addr_in    = 32'h20;
    bus.addr_valid = 1'b1;
    tick();
    bus.flush      = 1'b1;
    bus.addr_in    = 32'h40;
    #1;
    total++;
    if (bus.addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL fp_ready_flush got=%b need=0", bus.addr_ready);
    end
    tick();
    bus.flush = 1'b0;
    #1;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b1
        || bus.mem_addr !== 32'h20 || bus.addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL fp_drain v=%b req=%b addr=%h rdy=%b need 0/1/20/0",
               bus.inst_valid, bus.mem_req, bus.mem_addr,
               bus.addr_ready);
    end
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    #1;
    total++;
    if (bus.addr_ready !== 1'b0) begin
      bad++;
      $display("FAIL fp_ready_ack got=%b need=0", bus.addr_ready);
    end
    tick();
    bus.mem_ack = 1'b0;
    #1;
    total++;
    if (bus.addr_ready !== 1'b1 || bus.inst_valid !== 1'b0
        || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fp_after rdy=%b v=%b req=%b need 1/0/0",
               bus.addr_ready, bus.inst_valid, bus.mem_req);
    end
    bus.addr_valid = 1'b0;
  endtask

  task automatic test_flush_ack();
    bus.addr_in    = 32'h50;
    bus.addr_valid = 1'b1;
    tick();
    bus.addr_valid = 1'b0;
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'h5555;
    bus.flush      = 1'b1;
    tick();
    bus.mem_ack    = 1'b0;
    bus.flush      = 1'b0;
    #1;
    total++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req !== 1'b0
        || bus.addr_ready !== 1'b1) begin
      bad++;
      $display("FAIL fa_idle v=%b req=%b rdy=%b need 0/0/1",
               bus.inst_valid, bus.mem_req, bus.addr_ready);
    end
    fetch(32'h200, 32'hCAFE0200);
    #1;
    total++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200
        || bus.inst_out !== 32'hCAFE0200) begin
      bad++;
      $display("FAIL fa_next v=%b pc=%h out=%h need 1/200/cafe0200",
               bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      fetch(32'h1000 + 32'(i * 4), 32'h1000 + 32'(i * 4) + 32'h77);
    bus.addr_in    = 32'h100C;
    bus.addr_valid = 1'b1;
    tick();
    bus.addr_valid = 1'b0;
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'h100C + 32'h77;
    bus.inst_ready = 1'b1;
    tick();
    bus.mem_ack    = 1'b0;
    bus.inst_ready = 1'b0;
    #1;
    total++;
    if (bus.inst_pc !== 32'h1004 || bus.addr_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pushpop pc=%h rdy=%b need 1004/1",
               bus.inst_pc, bus.addr_ready);
    end
    for (int i = 1; i < 4; i++) begin
      e = 32'h1000 + 32'(i * 4);
      #1;
      total++;
      if (bus.inst_pc !== e || bus.inst_out !== e + 32'h77) begin
        bad++;
        $display("FAIL b2b_order pc=%h out=%h need pc=%h",
                 bus.inst_pc, bus.inst_out, e);
      end
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
    end
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = 32'h2000 + 32'(i * 4);
      bus.addr_valid = 1'b1;
      bus.addr_in    = e;
      #1;
      total++;
      if (bus.addr_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_rate i=%0d ready=%b need=1",
                 i, bus.addr_ready);
      end
      fetch(e, ~e);
      #1;
      total++;
      if (bus.inst_pc !== e || bus.inst_out !== ~e) begin
        bad++;
        $display("FAIL b2b_wrap i=%0d pc=%h out=%h need pc=%h",
                 i, bus.inst_pc, bus.inst_out, e);
      end
    end
    tick();
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_reset_midreq();
    bus.addr_in    = 32'h77;
    bus.addr_valid = 1'b1;
    tick();
    bus.addr_valid = 1'b0;
    rst_n          = 1'b0;
    tick();
    #1;
    total++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_midreq req=%b addr=%h need 0/0",
               bus.mem_req, bus.mem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    fetch_t      q[$];
    bit          busy  = 1'b0;
    bit          dead  = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic        av, fl, ack, ir, exp_rdy;
    logic [31:0] a, rd;
    rst_n          = 1'b0;
    bus.addr_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.inst_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      av  = ($urandom_range(0, 9) < 7);
      a   = $urandom;
      fl  = ($urandom_range(0, 15) == 0);
      ack = busy && ($urandom_range(0, 1) == 1);
      rd  = $urandom;
      ir  = (c < 300) ? ($urandom_range(0, 3) == 0)
                      : ($urandom_range(0, 1) == 1);
      bus.addr_valid = av;
      bus.addr_in    = a;
      bus.flush      = fl;
      bus.mem_ack    = ack;
      bus.mem_rdata  = rd;
      bus.inst_ready = ir;
      #1;
      exp_rdy = !busy && (q.size() < 4) && !fl;
      total++;
      if (bus.addr_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rnd_ready c=%0d got=%b need=%b",
                 c, bus.addr_ready, exp_rdy);
      end
      total++;
      if (bus.mem_req !== busy
          || (busy && bus.mem_addr !== raddr)) begin
        bad++;
        $display("FAIL rnd_mem c=%0d req=%b addr=%h need %b/%h",
                 c, bus.mem_req, bus.mem_addr, busy, raddr);
      end
      total++;
      if (bus.inst_valid !== (q.size() != 0)) begin
        bad++;
        $display("FAIL rnd_valid c=%0d got=%b need=%b",
                 c, bus.inst_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        total++;
        if (bus.inst_pc !== q[0].pc || bus.inst_out !== q[0].inst) begin
          bad++;
          $display("FAIL rnd_head c=%0d pc=%h out=%h need %h/%h",
                   c, bus.inst_pc, bus.inst_out, q[0].pc, q[0].inst);
        end
      end
      if (fl) begin
        q.delete();
        if (busy) begin
          if (ack) begin busy = 1'b0; dead = 1'b0; end
          else dead = 1'b1;
        end
      end else begin
        if (ir && q.size() != 0) void'(q.pop_front());
        if (busy && ack) begin
          if (!dead) q.push_back('{pc: raddr, inst: rd});
          busy = 1'b0;
          dead = 1'b0;
        end
        if (av && exp_rdy) begin
          busy  = 1'b1;
          raddr = a;
        end
      end
      tick();
    end
    bus.addr_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.inst_ready = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.addr_in    = '0;
    bus.addr_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_flush_pending();
    test_flush_ack();
    test_back_to_back();
    test_reset_midreq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
